fwd_sel_gen: RTL
================

Name: fwd_sel_gen

Overview:
- Generates the 2-bit operand-select codes consumed by the EX-stage 4:1 operand muxes (codes 0..3, one mux per ALU operand).
- Tracks in-flight register writes (EX, MEM, WB slots) in an internal shift pipeline.
- Compares them against the source registers of the instruction in ID, and registers the resulting selects so they are valid while that instruction is in EX.
- Also detects load-use hazards and raises a one-cycle stall.

Parameters:
- REG_ADDR_WIDTH, 5, width of register specifiers.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- hold  input  1  global pipeline freeze (e.g. memory wait); all state held.
- flush  input  1  kill instruction in ID; bubble enters EX.
- id_valid  input  1  ID holds a real instruction.
- id_rs1  input  REG_ADDR_WIDTH  operand A source register.
- id_rs2  input  REG_ADDR_WIDTH  operand B source register.
- id_rs1_used / id_rs2_used  input  1 each  operand actually reads the register.
- id_rd  input  REG_ADDR_WIDTH  destination of ID instruction.
- id_wen  input  1  ID instruction writes rd.
- id_is_load  input  1  ID instruction is a load.
- fwd_sel_a  output  2  select for operand A mux, registered.
- fwd_sel_b  output  2  select for operand B mux, registered.
- stall  output  1  load-use stall request, combinational.

Behaviour:
- Select encoding, as seen in EX:
  - 0 = register file.
  - 1 = EX/MEM result.
  - 2 = MEM/WB result.
  - 3 = retired-write holding register (value written back one cycle earlier).
- Internal slots EX, MEM, WB. Each slot holds {valid, wen, is_load, rd}. A slot is a "producer" iff valid & wen & rd != 0.
- Per advancing edge (hold=0):
  - WB<=MEM.
  - MEM<=EX.
  - EX<=ID fields, with valid = id_valid & ~stall & ~flush; otherwise the EX slot becomes a bubble with all fields 0.
- Select computation in ID, per operand (rsX, usedX), first match wins:
  - EX-slot producer with rd==rsX -> 1.
  - MEM-slot producer -> 2.
  - WB-slot producer -> 3.
  - Otherwise 0.
  - rsX==0 or usedX==0 -> 0.
  - The computed value is registered into fwd_sel_X on the advancing edge.
  - When the EX slot loads a bubble (stall, flush or id_valid=0), fwd_sel_a/b load 0.
- stall = id_valid & ~flush & (EX slot valid & is_load & producer) & ((rs1_used & rd==rs1) | (rs2_used & rd==rs2)).
  - stall is asserted for exactly one cycle per hazard: the bubble moves the load to MEM, after which its result forwards via code 2.
  - The upstream stages hold ID while stall=1. This block does not latch ID.
- hold=1:
  - All slots and fwd_sel_a/b are unchanged.
  - stall is still computed combinationally from current state.
  - hold takes priority over flush and stall for state updates.
- flush and stall in the same cycle: flush wins. stall reads 0, and the bubble is inserted.
- Reset, on an edge with reset=1, priority over hold:
  - All slots invalid.
  - fwd_sel_a = fwd_sel_b = 0.
  - stall reads 0 from the next cycle onward, because no slot is valid.
- Latency:
  - Selects: 1 cycle (ID compare -> EX register).
  - stall: 0 cycles.
- Operand A and operand B are evaluated independently and may forward from different slots.

Optional Feature:
- Macro FWD_STALL_CNT_EN.
- Defined:
  - Adds output stall_count, 16 bits.
  - Increments on each edge where stall=1 and hold=0 and reset=0.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: port and counter absent. Behaviour is otherwise identical.

Test Plan:
- Back-to-back ALU dependency:
  - Cycle n: ID rd=5 wen=1. Cycle n+1: ID rs1=5 used.
  - Required: fwd_sel_a=1 in cycle n+2; fwd_sel_b=0.
- Distance 2 and 3:
  - Producer rd=7, then a non-writing instruction, then a consumer with rs2=7 -> fwd_sel_b=2.
  - With two intervening instructions -> fwd_sel_b=3.
  - With three intervening instructions -> 0.
- Priority and r0:
  - Producers rd=3 (older) and rd=3 (younger), then consumer rs1=3 -> fwd_sel_a=1.
  - Producer rd=0, consumer rs1=0 -> 0.
- Load-use:
  - Load rd=9 in EX, ID rs2=9 used -> stall=1 for one cycle.
  - Next cycle stall=0; then fwd_sel_b=2 when the consumer reaches EX.
  - stall_count=1 when FWD_STALL_CNT_EN is defined.
- Hold and flush:
  - hold=1 for 3 cycles mid-sequence -> fwd_sel_a/b and stall unchanged across all three.
  - flush=1 with a load-use hazard present -> stall=0; next fwd_sel_a/b=0.
- Reset mid-stream:
  - Assert reset while slots are full with fwd_sel_a=2 -> after the edge, fwd_sel_a=fwd_sel_b=0, stall=0.
  - A consumer of rd from a pre-reset producer gets code 0.

Source files
------------

// File: rtl/fwd_sel_gen.sv
// Operand-forwarding select generator with load-use stall detection for a 5-stage pipeline.
// Optional saturating stall counter is enabled by defining FWD_STALL_CNT_EN.
module fwd_sel_gen #(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_wen,
    input  logic                      id_is_load,
    output logic [1:0]                fwd_sel_a,
    output logic [1:0]                fwd_sel_b,
    output logic                      stall
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [15:0]               stall_count
`endif
);

    typedef struct packed {
        logic                      valid;
        logic                      wen;
        logic                      is_load;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } slot_t;

    slot_t      ex_q, mem_q, wb_q;
    slot_t      ex_d;
    logic [1:0] sel_a_q, sel_b_q;
    logic [1:0] sel_a_d, sel_b_d;
    logic       advance;

    function automatic logic is_producer(input slot_t s);
        return s.valid && s.wen && (s.rd != '0);
    endfunction

    // Youngest in-flight writer wins, so EX is checked before MEM before WB.
    function automatic logic [1:0] fwd_code(input slot_t ex, input slot_t mem, input slot_t wb,
                                            input logic [REG_ADDR_WIDTH-1:0] rs,
                                            input logic used);
        if (!used || rs == '0) return 2'd0;
        if (is_producer(ex) && ex.rd == rs) return 2'd1;
        if (is_producer(mem) && mem.rd == rs) return 2'd2;
        if (is_producer(wb) && wb.rd == rs) return 2'd3;
        return 2'd0;
    endfunction

    always_comb begin
        stall = id_valid && !flush && ex_q.is_load && is_producer(ex_q) &&
                ((id_rs1_used && ex_q.rd == id_rs1) || (id_rs2_used && ex_q.rd == id_rs2));
    end

    always_comb begin
        advance = id_valid && !stall && !flush;
        ex_d    = '0;
        sel_a_d = 2'd0;
        sel_b_d = 2'd0;
        if (advance) begin
            ex_d.valid   = 1'b1;
            ex_d.wen     = id_wen;
            ex_d.is_load = id_is_load;
            ex_d.rd      = id_rd;
            sel_a_d      = fwd_code(ex_q, mem_q, wb_q, id_rs1, id_rs1_used);
            sel_b_d      = fwd_code(ex_q, mem_q, wb_q, id_rs2, id_rs2_used);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            sel_a_q <= 2'd0;
            sel_b_q <= 2'd0;
        end else if (!hold) begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= ex_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign fwd_sel_a = sel_a_q;
    assign fwd_sel_b = sel_b_q;

`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else if (!hold && stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule
